i2c_reg_slave: RTL and testbench

Write-only I2C responder. It receives the 3-byte frames our I2C write controller emits: slave address with R/W bit, sub-address, then data. It ACKs each byte on the open-drain data line and presents the decoded register write as a one-cycle strobe. It sits on the FPGA side of the I2C bus and lets board-level frames be looped back and checked on-chip, or lets the FPGA act as a configurable target.

---
 rtl/i2c_reg_slave.sv | 194 +++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
`timescale 1ns / 1ps
// i2c_reg_slave
//
// Write-only I2C target. Accepts 3-byte frames (address+W, sub-address, data),
// ACKs each byte on the open-drain SDA line, and issues a one-cycle register
// write strobe when the data byte's ACK clock completes.
//
// Ports:
//   CLOCK      system clock, at least 8x the SCL frequency
//   RESET_N    asynchronous active-low reset
//   I2C_SCLK   bus clock from the master
//   I2C_SDAT   open-drain data line; this block only drives 0 or z
//   REG_ADDR   sub-address of the last completed write
//   REG_DATA   data byte of the last completed write
//   REG_WE     one-CLOCK write strobe
//   BUSY       high whenever the FSM is not idle
//   ERR        one-CLOCK pulse when an addressed frame is cut short
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_DATA,
  output logic       REG_WE,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StSub,
    StSubAck,
    StData,
    StDataAck,
    StWaitStop,
    StIgnore
  } state_e;

  localparam logic [7:0] AddrWrite = {SLAVE_ADDR, 1'b0};

  // Synchronizers plus one history flop per line. Reset to 1 (idle bus) so
  // reset release never fabricates an edge.
  logic scl_meta_q, scl_s_q, scl_p_q;
  logic sda_meta_q, sda_s_q, sda_p_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_meta_q <= I2C_SCLK;
      scl_s_q    <= scl_meta_q;
      scl_p_q    <= scl_s_q;
      sda_meta_q <= I2C_SDAT;
      sda_s_q    <= sda_meta_q;
      sda_p_q    <= sda_s_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  always_comb begin
    scl_rise  = scl_s_q & ~scl_p_q;
    scl_fall  = ~scl_s_q & scl_p_q;
    start_det = scl_s_q & sda_p_q & ~sda_s_q;
    stop_det  = scl_s_q & ~sda_p_q & sda_s_q;
  end

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sub_q, sub_d;
  logic [7:0] data_q, data_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_data_q, reg_data_d;
  logic       we_q, we_d;
  logic       err_q, err_d;
  logic       sda_oe_q, sda_oe_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    data_d     = data_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    we_d       = 1'b0;
    err_d      = 1'b0;

    // Bus conditions win over any bit sample in the same cycle.
    if (stop_det) begin
      state_d = StIdle;
      err_d   = state_q inside {StAddrAck, StSub, StSubAck, StData, StDataAck};
    end else if (start_det) begin
      state_d = StAddr;
      shift_d = 8'h00;
      cnt_d   = 4'd0;
      err_d   = state_q inside {StSub, StSubAck, StData, StDataAck};
    end else begin
      unique case (state_q)
        StIdle: ;

        StAddr, StSub, StData: begin
          if (scl_rise && (cnt_q < 4'd8)) begin
            shift_d = {shift_q[6:0], sda_s_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && (cnt_q == 4'd8)) begin
            // Falling edge after bit 8 opens the ACK slot.
            if (state_q == StAddr) begin
              // R/W=1 also lands here since the compare includes bit 0.
              state_d = (shift_q == AddrWrite) ? StAddrAck : StIgnore;
            end else if (state_q == StSub) begin
              sub_d   = shift_q;
              state_d = StSubAck;
            end else begin
              data_d  = shift_q;
              state_d = StDataAck;
            end
          end
        end

        StAddrAck, StSubAck, StDataAck: begin
          // Falling edge ending the 9th clock closes the slot.
          if (scl_fall) begin
            cnt_d   = 4'd0;
            shift_d = 8'h00;
            if (state_q == StAddrAck) begin
              state_d = StSub;
            end else if (state_q == StSubAck) begin
              state_d = StData;
            end else begin
              state_d    = StWaitStop;
              reg_addr_d = sub_q;
              reg_data_d = data_q;
              we_d       = 1'b1;
            end
          end
        end

        StWaitStop, StIgnore: ;

        default: state_d = StIdle;
      endcase
    end

    // Registered so SDA is driven from a single flop, free of decode glitches.
    sda_oe_d = state_d inside {StAddrAck, StSubAck, StDataAck};
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      cnt_q      <= 4'd0;
      sub_q      <= 8'h00;
      data_q     <= 8'h00;
      reg_addr_q <= 8'h00;
      reg_data_q <= 8'h00;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      data_q     <= data_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      we_q       <= we_d;
      err_q      <= err_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

  assign REG_ADDR = reg_addr_q;
  assign REG_DATA = reg_data_q;
  assign REG_WE   = we_q;
  assign ERR      = err_q;
  assign BUSY     = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_reg_slave.sv
`timescale 1ns / 1ps
// Bench for i2c_reg_slave: bit-banged I2C master, frame-level model of the
// expected ACKs / writes / errors, and a per-cycle compare process.
module tb_i2c_reg_slave;

  localparam logic [6:0] SlaveAddr = 7'h1A;
  localparam logic [7:0] MatchByte = {SlaveAddr, 1'b0};
  localparam int         Q = 40;  // quarter SCL period, 4 CLOCKs

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       sda_drv;  // 1 = master releases the line
  wire        sda_bus;
  logic [7:0] reg_addr, reg_data;
  logic       reg_we, busy, err;

  assign sda_bus = sda_drv ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_reg_slave #(.SLAVE_ADDR(SlaveAddr)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus),
    .REG_ADDR(reg_addr),
    .REG_DATA(reg_data),
    .REG_WE  (reg_we),
    .BUSY    (busy),
    .ERR     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          failures = 0;
  int          we_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] wq[$];       // expected writes {addr, data}
  logic [15:0] hold = '0;   // model of REG_ADDR/REG_DATA between writes
  bit          ack_allow = 0;
  bit          in_frame = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Frame-level model.
  function automatic bit m_ack(input logic [7:0] b0, input int idx);
    return (b0 == MatchByte) && (idx < 3);
  endfunction
  function automatic bit m_err(input logic [7:0] b0, input int nfull);
    return (b0 == MatchByte) && (nfull == 1 || nfull == 2);
  endfunction
  function automatic bit m_write(input logic [7:0] b0, input int nfull);
    return (b0 == MatchByte) && (nfull >= 3);
  endfunction

  // Compare process.
  initial begin
    logic we_prev, err_prev;
    we_prev = 0;
    err_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = '0;
        chk("rst_we", reg_we, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
      end else begin
        if (reg_we) begin
          we_cnt++;
          if (wq.size() == 0) begin
            chk("unexpected_we", 1, 0);
          end else begin
            hold = wq.pop_front();
            chk("we_addr", reg_addr, hold[15:8]);
            chk("we_data", reg_data, hold[7:0]);
          end
          if (we_prev) chk("we_single", we_prev, 0);
        end else begin
          chk("hold_addr", reg_addr, hold[15:8]);
          chk("hold_data", reg_data, hold[7:0]);
        end
        if (err) begin
          err_cnt++;
          if (err_prev) chk("err_single", err_prev, 0);
        end
        if (sda_drv && !ack_allow) chk("sda_released", sda_bus, 1);
      end
      we_prev = reg_we;
      err_prev = err;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_cond();
    sda_drv = 1; #(Q);
    scl = 1;     #(Q);
    sda_drv = 0; #(Q);
    scl = 0;     #(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 0; #(Q);
    scl = 1;     #(Q);
    sda_drv = 1; #(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; #(Q);
    scl = 1;     #(2 * Q);
    scl = 0;     #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit ack_slot,
                           output bit got);
    got = 0;
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; #(Q);
      scl = 1;        #(2 * Q);
      if (i == 0) ack_allow = exp_ack;
      scl = 0;        #(Q);
    end
    if (ack_slot) begin
      sda_drv = 1; #(Q);
      scl = 1;     #(Q);
      got = (sda_bus === 1'b0);
      #(Q);
      scl = 0;     #(Q);
      ack_allow = 0;
    end
  endtask

  task automatic frame(input string name, input logic [7:0] b0, b1, b2, input int nfull,
                       input int npart, input bit rs_end, output logic [2:0] ackm,
                       output int derr, output int dwe);
    logic [7:0] bytes[3];
    int e0, w0;
    bit got;
    bytes = '{b0, b1, b2};
    ackm = '0;
    e0 = err_cnt;
    w0 = we_cnt;
    if (m_write(b0, nfull)) wq.push_back({b1, b2});
    if (!in_frame) begin
      start_cond();
      chk({name, "_busy_start"}, busy, 1);
    end
    in_frame = 1;
    for (int i = 0; i < nfull; i++) begin
      send_byte(bytes[i], m_ack(b0, i), 1'b1, got);
      ackm[i] = got;
      chk({name, "_ack"}, got, m_ack(b0, i));
    end
    if (nfull < 3) begin
      for (int p = 0; p < npart; p++) send_bit(bytes[nfull][7-p]);
    end
    if (rs_end) begin
      start_cond();
    end else begin
      chk({name, "_busy_pre_stop"}, busy, 1);
      stop_cond();
      in_frame = 0;
    end
    #(80);
    derr = err_cnt - e0;
    dwe = we_cnt - w0;
    chk({name, "_err"}, derr, m_err(b0, nfull));
    chk({name, "_we"}, dwe, m_write(b0, nfull));
    chk({name, "_wq_empty"}, wq.size(), 0);
    chk({name, "_busy_end"}, busy, rs_end);
  endtask

  initial begin
    logic [2:0] ackm;
    int derr, dwe;
    bit got;
    rst_n = 0;
    scl = 1;
    sda_drv = 1;
    repeat (4) @(negedge clk);
    chk("init_sda", sda_bus, 1);
    chk("init_addr", reg_addr, 8'h00);
    chk("init_data", reg_data, 8'h00);
    chk("init_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1;
    #(4 * Q);

    // Valid frame.
    frame("valid", 8'h34, 8'h0E, 8'h42, 3, 0, 0, ackm, derr, dwe);
    chk("valid_ackm_lit", ackm, 3'b111);
    chk("valid_we_lit", dwe, 1);
    chk("valid_err_lit", derr, 0);
    chk("valid_addr_lit", reg_addr, 8'h0E);
    chk("valid_data_lit", reg_data, 8'h42);

    // Address mismatch.
    frame("mismatch", 8'h36, 8'h0E, 8'h42, 3, 0, 0, ackm, derr, dwe);
    chk("mismatch_ackm_lit", ackm, 3'b000);
    chk("mismatch_we_lit", dwe, 0);

    // Read bit set.
    frame("read", 8'h35, 8'h0E, 8'h42, 3, 0, 0, ackm, derr, dwe);
    chk("read_ackm_lit", ackm, 3'b000);
    chk("read_err_lit", derr, 0);

    // Frame cut after sub-address.
    frame("short", 8'h34, 8'h0E, 8'h00, 2, 0, 0, ackm, derr, dwe);
    chk("short_ackm_lit", ackm, 3'b011);
    chk("short_err_lit", derr, 1);
    chk("short_addr_lit", reg_addr, 8'h0E);
    chk("short_data_lit", reg_data, 8'h42);

    // Repeated START mid sub-address, then a full frame.
    frame("rs_a", 8'h34, 8'h0E, 8'h00, 1, 3, 1, ackm, derr, dwe);
    chk("rs_a_err_lit", derr, 1);
    frame("rs_b", 8'h34, 8'h10, 8'hA5, 3, 0, 0, ackm, derr, dwe);
    chk("rs_b_we_lit", dwe, 1);
    chk("rs_b_addr_lit", reg_addr, 8'h10);
    chk("rs_b_data_lit", reg_data, 8'hA5);

    // Reset while SDA is driven in the sub-address ACK slot.
    start_cond();
    in_frame = 1;
    send_byte(8'h34, 1'b1, 1'b1, got);
    chk("rst_addr_ack", got, 1);
    send_byte(8'h0E, 1'b1, 1'b0, got);
    sda_drv = 1; #(Q);
    chk("rst_sub_ack_drive", sda_bus, 0);
    rst_n = 0;
    #1;
    chk("rst_sda_z", sda_bus, 1);
    chk("rst_busy_async", busy, 0);
    chk("rst_addr_async", reg_addr, 8'h00);
    chk("rst_data_async", reg_data, 8'h00);
    chk("rst_we_async", reg_we, 0);
    chk("rst_err_async", err, 0);
    #(Q - 1);
    scl = 1;
    #(Q);
    ack_allow = 0;
    in_frame = 0;
    rst_n = 1;
    #(4 * Q);
    chk("post_rst_we_count", we_cnt, 2);

    frame("post_rst", 8'h34, 8'h5A, 8'hC3, 3, 0, 0, ackm, derr, dwe);
    chk("post_rst_ackm_lit", ackm, 3'b111);
    chk("post_rst_addr_lit", reg_addr, 8'h5A);
    chk("post_rst_data_lit", reg_data, 8'hC3);

    #(4 * Q);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
